// File: rtl/ext_bus_ctrl_pkg.sv
// Shared definitions for the external asynchronous bus engine: FSM encodings and timer sizing.
package ext_bus_ctrl_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetup  = 3'd1;
  localparam logic [2:0] StStrobe = 3'd2;
  localparam logic [2:0] StHold   = 3'd3;
  localparam logic [2:0] StTurn   = 3'd4;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The timer holds at most max_cyc-1, so clog2(max_cyc) bits suffice (min 1).
  function automatic int unsigned tmr_width(input int unsigned max_cyc);
    return (max_cyc <= 2) ? 1 : $clog2(max_cyc);
  endfunction

endpackage

// File: rtl/ext_bus_ctrl_timer.sv
// Load/decrement down-counter; done is high while the count is zero.
module ext_bus_ctrl_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             done
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/ext_bus_ctrl.sv
// Single-beat read/write engine for an external asynchronous 8-bit device behind tri-state pads.
module ext_bus_ctrl
  import ext_bus_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned TURN_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_dout,
  output logic                  bus_t,
  input  logic [DATA_WIDTH-1:0] bus_din,
  output logic                  bus_cs_n,
  output logic                  bus_we_n,
  output logic                  bus_oe_n
);

  localparam int unsigned TimerW = tmr_width(max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC));

  logic [2:0]        state_q, state_d;
  logic              write_q, write_d;
  logic              accept;
  logic              active_d;
  logic              tmr_load, tmr_done;
  logic [TimerW-1:0] tmr_val;

  assign accept  = (state_q == StIdle) && req_valid;
  assign write_d = accept ? req_write : write_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (req_valid) state_d = StSetup;
      StSetup:  if (tmr_done) state_d = StStrobe;
      StStrobe: if (tmr_done) state_d = StHold;
      StHold:   if (tmr_done) state_d = write_q ? StTurn : StIdle;
      StTurn:   if (tmr_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Reload the timer on every state change with the new state's cycle count minus one.
  always_comb begin
    tmr_val = '0;
    case (state_d)
      StSetup:  tmr_val = TimerW'(SETUP_CYC - 1);
      StStrobe: tmr_val = TimerW'(STROBE_CYC - 1);
      StHold:   tmr_val = TimerW'(HOLD_CYC - 1);
      StTurn:   tmr_val = TimerW'(TURN_CYC - 1);
      default:  tmr_val = '0;
    endcase
  end

  assign tmr_load = (state_d != state_q);
  assign active_d = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);

  ext_bus_ctrl_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  // Outputs are registered from the next state so pad controls change cleanly on the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bus_addr  <= '0;
      bus_dout  <= '0;
      bus_t     <= 1'b1;
      bus_cs_n  <= 1'b1;
      bus_we_n  <= 1'b1;
      bus_oe_n  <= 1'b1;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      req_ready <= (state_d == StIdle);
      rsp_valid <= (state_q == StHold) && tmr_done;
      bus_cs_n  <= !active_d;
      bus_t     <= !(active_d && write_d);
      bus_we_n  <= !(write_d && (state_d == StStrobe));
      bus_oe_n  <= !(!write_d && (state_d == StStrobe));
      if (accept) begin
        bus_addr <= req_addr;
        if (req_write) bus_dout <= req_wdata;
      end
      if ((state_q == StStrobe) && tmr_done && !write_q) rsp_rdata <= bus_din;
    end
  end

endmodule
